demux_1_to_n_stream: RTL and testbench



---
 rtl/demux_1_to_n_stream_pkg.sv | 21 ++
 rtl/demux_stream_slot.sv | 65 ++++++
 rtl/demux_1_to_n_stream.sv | 85 ++++++++
 tb/tb_demux_1_to_n_stream.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1_to_n_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux_1_to_n_stream_pkg
// Shared definitions for the CRP16 stream demultiplexer:
//   CRP16_WORD_BITS : native CRP16 datapath word width
//   clog2()         : ceiling log2, used by instantiators to size select fields
// -----------------------------------------------------------------------------
package demux_1_to_n_stream_pkg;

    localparam int CRP16_WORD_BITS = 16;

    // Smallest n with 2**n >= value. Returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_stream_slot.sv
// -----------------------------------------------------------------------------
// demux_stream_slot
// One-entry output register slice for a single demux channel.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   load_i         : write data_i into the slot this edge (wins over drain)
//   data_i         : word to load
//   ready_i        : consumer accepts the held word this edge
//   valid_o        : slot holds a word
//   data_o         : held word, all zeros while the slot is empty
// -----------------------------------------------------------------------------
module demux_stream_slot
    import demux_1_to_n_stream_pkg::*;
#(
    parameter int bits = CRP16_WORD_BITS
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic [bits-1:0] data_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [bits-1:0] data_o
);

    logic            valid_q, valid_d;
    logic [bits-1:0] data_q,  data_d;

    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            // A load on the same edge as a drain refills the slot, which is
            // what gives one word per cycle per channel.
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            // Clearing the data on drain keeps the empty slot reading zero.
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    // NOTE: the data register is reset along with the flag; an empty slot must
    // present zeros on its output slice straight out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    // Gating by the flag keeps the zero-when-empty guarantee independent of
    // how the data register was last left.
    assign data_o  = data_q & {bits{valid_q}};

endmodule

// File: rtl/demux_1_to_n_stream.sv
// -----------------------------------------------------------------------------
// demux_1_to_n_stream
// Registered 1-to-N stream demultiplexer with valid/ready on every side.
// Each accepted input word is routed to the channel named by in_select and
// held in that channel's one-entry slot; out-of-range selects are dropped and
// flagged on err_select for one cycle.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   in_data        : input word
//   in_select      : destination channel of in_data
//   in_valid       : producer has a word
//   in_ready       : word accepted this cycle (independent of in_valid)
//   out_data       : channel i at [i*bits +: bits], zero while empty
//   out_valid      : channel i holds a word
//   out_ready      : consumer i takes its word this cycle
//   err_select     : one-cycle pulse after an out-of-range word is dropped
// -----------------------------------------------------------------------------
module demux_1_to_n_stream
    import demux_1_to_n_stream_pkg::*;
#(
    parameter int bits     = CRP16_WORD_BITS,
    parameter int channels = 4,
    parameter int sel_bits = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [bits-1:0]          in_data,
    input  logic [sel_bits-1:0]      in_select,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [channels*bits-1:0] out_data,
    output logic [channels-1:0]      out_valid,
    input  logic [channels-1:0]      out_ready,
    output logic                     err_select
);

    logic [channels-1:0] load_en;
    logic                sel_hit;
    logic                sel_ready;
    logic                err_d, err_q;

    // Select decode: one-hot load enables plus the in_ready multiplexer.
    // A select that matches no channel is out of range; such a word is always
    // accepted and discarded.
    always_comb begin
        load_en   = '0;
        sel_hit   = 1'b0;
        sel_ready = 1'b1;
        for (int i = 0; i < channels; i++) begin
            if (in_select == sel_bits'(i)) begin
                sel_hit    = 1'b1;
                sel_ready  = !out_valid[i] || out_ready[i];
                load_en[i] = in_valid && sel_ready;
            end
        end
        err_d = in_valid && !sel_hit;
    end

    assign in_ready = sel_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_select = err_q;

    for (genvar g = 0; g < channels; g++) begin : g_slot
        demux_stream_slot #(
            .bits (bits)
        ) u_slot (
            .clock   (clock),
            .reset_n (reset_n),
            .load_i  (load_en[g]),
            .data_i  (in_data),
            .ready_i (out_ready[g]),
            .valid_o (out_valid[g]),
            .data_o  (out_data[g*bits +: bits])
        );
    end

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_1_to_n_stream
// Scoreboard bench for demux_1_to_n_stream. dut4 (4 channels) is driven by
// directed and random traffic; a per-channel queue holds the words the model
// expects each channel to present, and a negedge monitor compares the DUT
// against the queue heads. dut3 (3 channels) covers the out-of-range select.
// -----------------------------------------------------------------------------
module tb_demux_1_to_n_stream;
    import demux_1_to_n_stream_pkg::*;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset_n;

    logic [W-1:0]  in_data;
    logic [1:0]    in_select;
    logic          in_valid;
    logic          in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic          err_select;

    logic [W-1:0]  d3_in_data;
    logic [1:0]    d3_in_select;
    logic          d3_in_valid;
    logic          d3_in_ready;
    logic [3*W-1:0] d3_out_data;
    logic [2:0]    d3_out_valid;
    logic [2:0]    d3_out_ready;
    logic          d3_err_select;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] exp_q[4][$];

    always #5 clock = ~clock;

    demux_1_to_n_stream #(.bits(W), .channels(4), .sel_bits(2)) dut4 (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_select (err_select)
    );

    demux_1_to_n_stream #(.bits(W), .channels(3), .sel_bits(clog2(3))) dut3 (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (d3_in_data),
        .in_select  (d3_in_select),
        .in_valid   (d3_in_valid),
        .in_ready   (d3_in_ready),
        .out_data   (d3_out_data),
        .out_valid  (d3_out_valid),
        .out_ready  (d3_out_ready),
        .err_select (d3_err_select)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the visible state against the model, then retires
    // every word whose consumer takes it on the coming edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && mon_en) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("ch%0d_valid", i), 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
                    if (exp_q[i].size() != 0)
                        check($sformatf("ch%0d_data", i), 64'(out_data[i*W +: W]), 64'(exp_q[i][0]));
                    else
                        check($sformatf("ch%0d_zero", i), 64'(out_data[i*W +: W]), 64'd0);
                end
                check("in_ready", 64'(in_ready),
                      64'((exp_q[in_select].size() == 0) || out_ready[in_select]));
                check("err_select_4ch", 64'(err_select), 64'd0);
                for (int i = 0; i < 4; i++) begin
                    if (exp_q[i].size() != 0 && out_ready[i])
                        void'(exp_q[i].pop_front());
                end
            end
        end
    end

    // One cycle on dut4. Entered and left at posedge+1. Acceptance comes from
    // the model; rdy is the DUT's in_ready sampled at the negedge.
    task automatic cycle4(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                          input logic [3:0] r, output bit acc, output logic rdy);
        in_valid  = v;
        in_select = s;
        in_data   = d;
        out_ready = r;
        @(negedge clock);
        rdy = in_ready;
        #1;
        // Queue was already drained for this edge, so an empty-or-draining
        // slot shows as size 0 or ready high.
        acc = v && ((exp_q[s].size() == 0) || r[s]);
        if (acc) exp_q[s].push_back(d);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit          acc;
        logic        rdy;
        bit          hold;
        logic        v;
        logic [1:0]  hs;
        logic [W-1:0] hd;

        // Reset with random inputs.
        reset_n = 1'b0;
        repeat (4) begin
            in_valid     = 1'($urandom);
            in_select    = 2'($urandom);
            in_data      = W'($urandom);
            out_ready    = 4'($urandom);
            d3_in_valid  = 1'($urandom);
            d3_in_select = 2'($urandom);
            d3_in_data   = W'($urandom);
            d3_out_ready = 3'($urandom);
            @(negedge clock);
            check("rst_valid", 64'(out_valid), 64'd0);
            check("rst_data", out_data, 64'd0);
            check("rst_err", 64'(err_select), 64'd0);
            check("rst_ready", 64'(in_ready), 64'd1);
            check("rst3_valid", 64'(d3_out_valid), 64'd0);
            check("rst3_ready", 64'(d3_in_ready), 64'd1);
        end
        in_valid    = 1'b0;
        out_ready   = '0;
        d3_in_valid = 1'b0;
        d3_out_ready = '0;
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst3_valid", 64'(d3_out_valid), 64'd0);
        mon_en = 1'b1;

        // Single route.
        cycle4(1'b1, 2'd2, 16'hBEEF, 4'b0000, acc, rdy);
        check("route_valid", 64'(out_valid), 64'b0100);
        check("route_data", out_data, {16'h0, 16'hBEEF, 32'h0});
        cycle4(1'b0, 2'd0, 16'h0, 4'b0100, acc, rdy);
        check("route_drain_valid", 64'(out_valid), 64'b0000);
        check("route_drain_data", out_data, 64'd0);

        // Backpressure on slot 1, bypass to slot 3.
        cycle4(1'b1, 2'd1, 16'hAAAA, 4'b0000, acc, rdy);
        cycle4(1'b1, 2'd1, 16'h5555, 4'b0000, acc, rdy);
        check("bp_ready_low", 64'(rdy), 64'd0);
        check("bp_slot1_kept", 64'(out_data[1*W +: W]), 64'hAAAA);
        cycle4(1'b1, 2'd3, 16'h3333, 4'b0000, acc, rdy);
        check("bp_other_ready", 64'(rdy), 64'd1);
        check("bp_slot3", 64'(out_data[3*W +: W]), 64'h3333);
        check("bp_valid", 64'(out_valid), 64'b1010);
        cycle4(1'b0, 2'd0, 16'h0, 4'b1010, acc, rdy);

        // Full throughput on channel 0.
        for (int k = 1; k <= 8; k++) begin
            cycle4(1'b1, 2'd0, W'(k), 4'b0001, acc, rdy);
            check("thru_ready", 64'(rdy), 64'd1);
            check("thru_word", 64'(out_data[0 +: W]), 64'(k));
        end
        cycle4(1'b0, 2'd0, 16'h0, 4'b0001, acc, rdy);
        check("thru_empty", 64'(out_valid), 64'd0);

        // Out-of-range select on the 3-channel instance.
        d3_in_valid  = 1'b1;
        d3_in_select = 2'd3;
        d3_in_data   = 16'h1234;
        #3;
        check("oor_ready", 64'(d3_in_ready), 64'd1);
        @(posedge clock);
        #1;
        d3_in_valid = 1'b0;
        check("oor_err_high", 64'(d3_err_select), 64'd1);
        check("oor_no_valid", 64'(d3_out_valid), 64'd0);
        check("oor_no_data", d3_out_data, 64'd0);
        @(posedge clock);
        #1;
        check("oor_err_low", 64'(d3_err_select), 64'd0);
        d3_in_valid  = 1'b1;
        d3_in_select = 2'd1;
        d3_in_data   = 16'h5678;
        @(posedge clock);
        #1;
        d3_in_valid = 1'b0;
        check("d3_route_valid", 64'(d3_out_valid), 64'b010);
        check("d3_route_data", d3_out_data, {16'h0, 16'h5678, 16'h0});
        check("d3_route_err", 64'(d3_err_select), 64'd0);
        d3_out_ready = 3'b010;
        @(posedge clock);
        #1;
        d3_out_ready = '0;
        check("d3_drain", 64'(d3_out_valid), 64'd0);

        // Random traffic; a refused word is held until accepted.
        hold = 1'b0;
        hs   = '0;
        hd   = '0;
        repeat (400) begin
            v = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!hold) begin
                hs = 2'($urandom);
                hd = W'($urandom);
            end
            cycle4(v, hs, hd, 4'($urandom), acc, rdy);
            hold = v && !acc;
        end
        repeat (3) cycle4(1'b0, 2'd0, 16'h0, 4'hF, acc, rdy);
        check("rand_drained", 64'(out_valid), 64'd0);

        // Reset mid-operation.
        for (int i = 0; i < 4; i++)
            cycle4(1'b1, 2'(i), W'(16'hC000 + i), 4'b0000, acc, rdy);
        check("fill_valid", 64'(out_valid), 64'hF);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", out_data, 64'd0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;
        repeat (3) cycle4(1'b0, 2'd0, 16'h0, 4'b0000, acc, rdy);
        check("after_rst_valid", 64'(out_valid), 64'd0);
        check("after_rst_data", out_data, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
